// File: rtl/line_fill_buffer.sv
// Line fill buffer: gathers BEATS memory beats in critical-word-first wrap order
// into one LINE_W line and pulses line_we for one cycle once the line is complete.

module lfb_slot #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         we,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (we) q <= d;
   end
endmodule

module line_fill_buffer #(
   parameter int BEAT_W = 64,
   parameter int BEATS  = 8,
   parameter int LINE_W = 512
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fill_start,
   input  logic [$clog2(BEATS)-1:0] start_offset,
   input  logic                     mem_valid,
   input  logic [BEAT_W-1:0]        mem_data,
   output logic                     mem_ready,
   output logic [LINE_W-1:0]        line_data,
   output logic                     line_we,
   output logic                     busy,
   output logic [$clog2(BEATS):0]   beat_cnt
);
   localparam int OFS_W = $clog2(BEATS);
   localparam int CNT_W = OFS_W + 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t                         state, state_nxt;
   logic [OFS_W-1:0]               ofs, ofs_nxt;
   logic [CNT_W-1:0]               cnt_nxt;
   logic [OFS_W-1:0]               wr_slot;
   logic                           accept;
   logic [BEATS-1:0][BEAT_W-1:0]   slot_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         ofs      <= '0;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         ofs      <= ofs_nxt;
         beat_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ofs_nxt   = ofs;
      cnt_nxt   = beat_cnt;
      mem_ready = 1'b0;
      line_we   = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            if (fill_start) begin
               ofs_nxt   = start_offset;
               cnt_nxt   = '0;
               state_nxt = FILL;
            end
         end
         FILL: begin
            mem_ready = 1'b1;
            busy      = 1'b1;
            if (mem_valid) begin
               cnt_nxt = beat_cnt + CNT_W'(1);
               if (beat_cnt == CNT_W'(BEATS - 1)) state_nxt = WRITE;
            end
         end
         WRITE: begin
            line_we   = 1'b1;
            busy      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Truncation to OFS_W bits gives the modulo-BEATS wrap for free.
   assign accept  = mem_ready & mem_valid;
   assign wr_slot = ofs + beat_cnt[OFS_W-1:0];

   for (genvar g = 0; g < BEATS; g++) begin : g_slot
      lfb_slot #(.W(BEAT_W)) u_slot (
         .clk   (clk),
         .reset (reset),
         .we    (accept && (wr_slot == OFS_W'(g))),
         .d     (mem_data),
         .q     (slot_q[g])
      );
   end

   assign line_data = slot_q;
endmodule

// File: tb/tb_line_fill_buffer.sv
// Directed bench for line_fill_buffer: per-cycle vector table for reset and an
// aligned fill, then hand-written sequences for wrap, stalls, ignored events and reset.

module tb_line_fill_buffer;
   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         fill_start = 1'b0;
   logic [2:0]   start_offset = '0;
   logic         mem_valid = 1'b0;
   logic [63:0]  mem_data = '0;
   logic         mem_ready;
   logic [511:0] line_data;
   logic         line_we;
   logic         busy;
   logic [3:0]   beat_cnt;

   logic [511:0] lreg;
   int           we_cnt = 0;
   int           n_cmp = 0;
   int           n_bad = 0;

   line_fill_buffer dut (
      .clk          (clk),
      .reset        (reset),
      .fill_start   (fill_start),
      .start_offset (start_offset),
      .mem_valid    (mem_valid),
      .mem_data     (mem_data),
      .mem_ready    (mem_ready),
      .line_data    (line_data),
      .line_we      (line_we),
      .busy         (busy),
      .beat_cnt     (beat_cnt)
   );

   always #5 clk = ~clk;

   // downstream line register model and write-pulse counter
   always @(posedge clk) if (line_we) lreg <= line_data;
   always @(negedge clk) if (line_we) we_cnt++;

   typedef struct {
      logic        rst;
      logic        fs;
      logic [2:0]  so;
      logic        mv;
      logic [63:0] md;
      logic        e_rdy;
      logic        e_we;
      logic        e_busy;
      logic [3:0]  e_cnt;
   } vec_t;

   vec_t tv[13];

   localparam logic [511:0] LINE_ALIGNED =
      {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0};
   localparam logic [511:0] LINE_WRAP6 =
      {64'hA1, 64'hA0, 64'hA7, 64'hA6, 64'hA5, 64'hA4, 64'hA3, 64'hA2};
   localparam logic [511:0] LINE_OFS2 =
      {64'hC5, 64'hC4, 64'hC3, 64'hC2, 64'hC1, 64'hC0, 64'hC7, 64'hC6};
   localparam logic [511:0] LINE_ONE8 =
      {64'h8, 64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input string name, input logic rdy, input logic we, input logic bsy,
                          input logic [3:0] cnt);
      chk(name, 512'({mem_ready, line_we, busy, beat_cnt}), 512'({rdy, we, bsy, cnt}));
   endtask

   // One complete fill. stalls holds a 4-bit stall count after each beat k.
   // junk: fill_start/offset 3 presented at beat_cnt=4, and a beat offered during WRITE.
   task automatic fill(input string name, input logic [2:0] so, input logic [63:0] base,
                       input logic [63:0] step, input logic [31:0] stalls, input bit junk,
                       output int lat);
      fill_start   = 1'b1;
      start_offset = so;
      tick();
      fill_start = 1'b0;
      lat = 0;
      for (int k = 0; k < 8; k++) begin
         mem_valid = 1'b1;
         mem_data  = base + 64'(k) * step;
         if (junk && k == 4) begin
            fill_start   = 1'b1;
            start_offset = 3'd3;
         end
         tick();
         lat++;
         fill_start = 1'b0;
         mem_valid  = 1'b0;
         mem_data   = 64'hBADB_ADBA_DBAD_BADB;
         for (int s = 0; s < int'(stalls[4*k +: 4]); s++) begin
            tick();
            lat++;
            chk({name, " stall cnt"}, 512'(beat_cnt), 512'(k + 1));
         end
      end
      chk_ctl({name, " write"}, 1'b0, 1'b1, 1'b1, 4'd8);
      mem_valid = junk;
      mem_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      mem_valid = 1'b0;
   endtask

   initial begin
      int lat;
      int we0;

      tv[0]  = '{1, 0, 0, 0, 64'h0,    0, 0, 0, 4'd0};
      tv[1]  = '{1, 0, 0, 0, 64'h0,    0, 0, 0, 4'd0};
      tv[2]  = '{0, 0, 0, 1, 64'hFFFF, 0, 0, 0, 4'd0};
      tv[3]  = '{0, 1, 0, 0, 64'h0,    1, 0, 1, 4'd0};
      for (int k = 0; k < 8; k++)
         tv[4+k] = '{0, 0, 0, 1, 64'(k), (k != 7), (k == 7), 1, 4'(k + 1)};
      tv[12] = '{0, 0, 0, 0, 64'h0,    0, 0, 0, 4'd8};

      for (int i = 0; i < 13; i++) begin
         reset        = tv[i].rst;
         fill_start   = tv[i].fs;
         start_offset = tv[i].so;
         mem_valid    = tv[i].mv;
         mem_data     = tv[i].md;
         tick();
         chk_ctl($sformatf("vec%0d ctl", i), tv[i].e_rdy, tv[i].e_we, tv[i].e_busy, tv[i].e_cnt);
         if (i == 2)  chk("idle beat ignored", line_data, '0);
         if (i == 11) chk("aligned line", line_data, LINE_ALIGNED);
         if (i == 12) chk("downstream reg", lreg, LINE_ALIGNED);
      end
      fill_start = 1'b0;
      mem_valid  = 1'b0;
      chk("aligned we pulses", 512'(we_cnt), 512'(1));

      we0 = we_cnt;
      fill("wrap6", 3'd6, 64'hA0, 64'h1, 32'h0, 1'b0, lat);
      chk("wrap6 line", line_data, LINE_WRAP6);
      chk("wrap6 latency", 512'(lat + 1), 512'(9));
      chk("wrap6 pulses", 512'(we_cnt - we0), 512'(1));

      we0 = we_cnt;
      fill("ignored", 3'd2, 64'hC0, 64'h1, 32'h0, 1'b1, lat);
      chk("ignored line", line_data, LINE_OFS2);
      chk_ctl("ignored idle", 1'b0, 1'b0, 1'b0, 4'd8);
      tick();
      chk("ignored pulses", 512'(we_cnt - we0), 512'(1));

      we0 = we_cnt;
      fill("stall", 3'd0, 64'h0, 64'h1, (32'h3 << 4) | (32'h1 << 16), 1'b0, lat);
      chk("stall line", line_data, LINE_ALIGNED);
      chk("stall latency", 512'(lat + 1), 512'(13));
      chk("stall pulses", 512'(we_cnt - we0), 512'(1));

      // reset part-way through a fill
      we0 = we_cnt;
      fill_start   = 1'b1;
      start_offset = 3'd0;
      tick();
      fill_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         mem_valid = 1'b1;
         mem_data  = 64'hDEAD;
         tick();
      end
      chk("midfill cnt", 512'(beat_cnt), 512'(5));
      mem_valid = 1'b0;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      chk("midfill line cleared", line_data, '0);
      chk_ctl("midfill ctl", 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      tick();
      chk("midfill no pulse", 512'(we_cnt - we0), 512'(0));
      fill("refill", 3'd0, 64'h1, 64'h1, 32'h0, 1'b0, lat);
      chk("refill line", line_data, LINE_ONE8);
      chk("refill pulses", 512'(we_cnt - we0), 512'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
